// File: rtl/mc_controller_v2.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with
// settle counter, mem_ready handshake + timeout, single-cycle commit strobes
// and an illegal-opcode / bus-timeout trap state.
module mc_controller_v2 #(
    parameter int SETTLE_CYCLES = 3,
    parameter int MEM_TIMEOUT   = 15,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       alu_lsb,
    input  logic       mem_ready,
    input  logic       trap_ack,
    output logic       mem_req,
    output logic       mem_write,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [1:0] alu_op,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
        ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, EXECU = 4'd11, TRAP = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cause_n;
    logic             is_mem, commit, timeout, taken, cnt_clr;

    // Commit/timeout qualification; strobes are suppressed while reset is held
    always_comb begin
        is_mem  = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
        if (is_mem)
            commit = mem_ready;
        else
            commit = (state != TRAP) && (cnt == CNT_W'(SETTLE_CYCLES - 1));
        commit  = commit && !reset;
        timeout = is_mem && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));
        cnt_clr = commit || timeout || (state == TRAP);
        case (funct3)
            3'b000:         taken = zero;
            3'b001:         taken = ~zero;
            3'b100, 3'b110: taken = alu_lsb;
            3'b101, 3'b111: taken = ~alu_lsb;
            default:        taken = 1'b0;
        endcase
    end

    // State, dwell counter and latched trap cause
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            cnt        <= '0;
            trap_cause <= 2'b00;
        end else begin
            state      <= state_n;
            trap_cause <= cause_n;
            cnt        <= cnt_clr ? '0 : cnt + 1'b1;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_n      = state;
        cause_n      = trap_cause;
        mem_req      = is_mem && !reset;
        mem_write    = 1'b0;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        imm_src      = 3'b000;
        alu_op       = 2'b00;
        trap         = 1'b0;
        state_dbg    = state;
        if (timeout) begin
            state_n = TRAP;
            cause_n = 2'b10;
        end
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = commit;
                pc_write   = commit;
                if (commit) state_n = DECODE;
            end
            DECODE: begin
                alu_src_a = (op == OP_JAL || op == OP_BR) ? 2'b01 : 2'b10;
                alu_src_b = 2'b01;
                case (op)
                    OP_STORE:          imm_src = 3'b001;
                    OP_BR:             imm_src = 3'b010;
                    OP_LUI, OP_AUIPC:  imm_src = 3'b011;
                    OP_JAL:            imm_src = 3'b100;
                    default:           imm_src = 3'b000;
                endcase
                if (commit) begin
                    case (op)
                        OP_LOAD, OP_STORE: state_n = MEMADR;
                        OP_R:              state_n = EXECR;
                        OP_IMM, OP_JALR:   state_n = EXECI;
                        OP_LUI, OP_AUIPC:  state_n = EXECU;
                        OP_JAL:            state_n = JAL;
                        OP_BR:             state_n = BRANCH;
                        default: begin
                            state_n = TRAP;
                            cause_n = 2'b01;
                        end
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
                if (commit) state_n = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD, MEMWRITE: begin
                adr_src      = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                mem_write    = (state == MEMWRITE) && commit;
                if (commit) state_n = (state == MEMREAD) ? MEMWB : FETCH;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = commit;
                if (commit) state_n = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                if (commit) state_n = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                imm_src   = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b101 : 3'b000;
                if (commit) state_n = ALUWB;
            end
            EXECU: begin
                alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b011;
                if (commit) state_n = ALUWB;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                pc_src    = 1'b1;
                pc_write  = commit;
                if (commit) state_n = ALUWB;
            end
            ALUWB: begin
                result_src = (op == OP_JAL || op == OP_JALR) ? 2'b11 : 2'b00;
                reg_write  = commit;
                if (commit) state_n = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b11;
                pc_src    = taken;
                pc_write  = commit && taken;
                if (commit) state_n = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
                if (trap_ack) begin
                    state_n = FETCH;
                    cause_n = 2'b00;
                end
            end
            default: begin
                state_n = FETCH;
                cause_n = 2'b00;
            end
        endcase
    end
endmodule
